// File: rtl/dsp_mac_pipe.sv
// Pre-add / multiply / post-add MAC: P = (acc ? P : C) + A*(D +/- B), optional bypass.
// Latency 4 ce-enabled cycles from in_valid to out_valid, one result per ce-cycle.
// No backpressure: ce low freezes every stage; in_valid-low beats travel as bubbles.
module dsp_mac_pipe #(
    parameter int A_W    = 18,
    parameter int BD_W   = 18,
    parameter int C_W    = 48,
    parameter int P_W    = 48,
    parameter int SIGNED = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ce,
    input  logic            in_valid,
    input  logic [2:0]      opmode,
    input  logic [A_W-1:0]  A,
    input  logic [BD_W-1:0] B,
    input  logic [BD_W-1:0] D,
    input  logic [C_W-1:0]  C,
    input  logic            clr_acc,
    output logic [P_W-1:0]  P,
    output logic            out_valid,
    output logic            ovf
);
    localparam int PA_W = BD_W + 1;
    localparam int M_W  = A_W + BD_W + 1;
    localparam bit SGN  = (SIGNED != 0);

    logic [A_W-1:0]  a1_q, a2_q;
    logic [BD_W-1:0] b1_q, d1_q;
    logic [C_W-1:0]  c1_q, c2_q, c3_q;
    logic [2:0]      op1_q;
    logic            acc2_q, acc3_q;
    logic            v1_q, v2_q, v3_q;
    logic [PA_W-1:0] pa2_q;
    logic [M_W-1:0]  m3_q;
    logic [P_W-1:0]  p_q;
    logic            ovf_q, vld_q;

    logic [PA_W-1:0] bx, dx, pa_d;
    logic [M_W-1:0]  ax, pax, m_d;
    logic [P_W-1:0]  cx, mx, acc_op;
    logic [P_W:0]    sum_d;
    logic            ovf_d;

    always_comb begin
        bx = '0;
        dx = '0;
        if (SGN) begin
            bx = PA_W'($signed(b1_q));
            dx = PA_W'($signed(d1_q));
        end else begin
            bx = PA_W'(b1_q);
            dx = PA_W'(d1_q);
        end
        pa_d = '0;
        if (op1_q[1])
            pa_d = bx;
        else if (op1_q[0])
            pa_d = dx - bx;
        else
            pa_d = dx + bx;
    end

    // Operands widened to the full product width so the low M_W bits are exact for both signednesses.
    always_comb begin
        ax  = '0;
        pax = '0;
        if (SGN) begin
            ax  = M_W'($signed(a2_q));
            pax = M_W'($signed(pa2_q));
        end else begin
            ax  = M_W'(a2_q);
            pax = M_W'(pa2_q);
        end
        m_d = ax * pax;
    end

    always_comb begin
        cx = '0;
        mx = '0;
        if (SGN) begin
            cx = P_W'($signed(c3_q));
            mx = P_W'($signed(m3_q));
        end else begin
            cx = P_W'(c3_q);
            mx = P_W'(m3_q);
        end
        acc_op = '0;
        if (!acc3_q)
            acc_op = cx;
        else if (!clr_acc)
            acc_op = p_q;
        sum_d = {1'b0, acc_op} + {1'b0, mx};
        ovf_d = sum_d[P_W];
        if (SGN)
            ovf_d = (acc_op[P_W-1] == mx[P_W-1]) && (sum_d[P_W-1] != acc_op[P_W-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1_q   <= '0;
            b1_q   <= '0;
            d1_q   <= '0;
            c1_q   <= '0;
            op1_q  <= '0;
            v1_q   <= 1'b0;
            a2_q   <= '0;
            pa2_q  <= '0;
            c2_q   <= '0;
            acc2_q <= 1'b0;
            v2_q   <= 1'b0;
            m3_q   <= '0;
            c3_q   <= '0;
            acc3_q <= 1'b0;
            v3_q   <= 1'b0;
            p_q    <= '0;
            ovf_q  <= 1'b0;
            vld_q  <= 1'b0;
        end else if (ce) begin
            a1_q   <= A;
            b1_q   <= B;
            d1_q   <= D;
            c1_q   <= C;
            op1_q  <= opmode;
            v1_q   <= in_valid;
            a2_q   <= a1_q;
            pa2_q  <= pa_d;
            c2_q   <= c1_q;
            acc2_q <= op1_q[2];
            v2_q   <= v1_q;
            m3_q   <= m_d;
            c3_q   <= c2_q;
            acc3_q <= acc2_q;
            v3_q   <= v2_q;
            vld_q  <= v3_q;
            if (v3_q) begin
                p_q   <= sum_d[P_W-1:0];
                ovf_q <= ovf_d;
            end else if (clr_acc) begin
                p_q   <= '0;
                ovf_q <= 1'b0;
            end
        end
    end

    assign P         = p_q;
    assign ovf       = ovf_q;
    assign out_valid = vld_q;
endmodule
